// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the instruction-cache line fill controller.
package icache_pkg;
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_OFF_W = 5;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} fill_state_t;
endpackage

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: fetches an 8-word I-cache line on a miss and strobes it into the cache.
// Define ICACHE_CRIT_WORD_FIRST_EN to fetch the missed word first and forward it early.
module icache_fill_ctrl
   import icache_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] PC,
   input  logic        miss,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [31:0] mem_addr,
   output logic        mem_rden,
   output logic [31:0] w0,
   output logic [31:0] w1,
   output logic [31:0] w2,
   output logic [31:0] w3,
   output logic [31:0] w4,
   output logic [31:0] w5,
   output logic [31:0] w6,
   output logic [31:0] w7,
   output logic        update,
   output logic        stall,
   output logic        busy,
   output logic [31:0] crit_word,
   output logic        crit_valid
);
`ifdef ICACHE_CRIT_WORD_FIRST_EN
   localparam bit CRIT_EN = 1'b1;
`else
   localparam bit CRIT_EN = 1'b0;
`endif
   fill_state_t state, state_nxt;
   logic [31:LINE_OFF_W] line_tag;
   logic [2:0] miss_off, issue_cnt, word_idx;
   logic [3:0] recv_cnt;
   logic [WORDS_PER_LINE-1:0][31:0] line;
   logic take, last, unused_pc;
   // Word index wraps mod 8, so critical-word-first order falls out of the 3-bit add.
   assign word_idx = issue_cnt + (CRIT_EN ? miss_off : 3'd0);
   assign take = state == WAIT && mem_rvalid;
   assign last = recv_cnt == 4'(WORDS_PER_LINE - 1);
   assign mem_addr = {line_tag, word_idx, 2'b00};
   assign stall = miss | busy;
   assign unused_pc = ^PC[1:0];
   always_ff @(posedge CLK)
      state <= !RST_N ? IDLE : state_nxt;
   always_comb begin
      state_nxt = state;
      mem_rden = 1'b0;
      update = 1'b0;
      busy = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            state_nxt = miss ? REQ : IDLE;
         end
         REQ: begin
            mem_rden = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: state_nxt = take ? (last ? UPDATE : REQ) : WAIT;
         UPDATE: begin
            update = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK)
      if (!RST_N) begin
         line_tag <= '0;
         miss_off <= '0;
         issue_cnt <= '0;
         recv_cnt <= '0;
         line <= '0;
      end else if (state == IDLE && miss) begin
         line_tag <= PC[31:LINE_OFF_W];
         miss_off <= PC[LINE_OFF_W-1:2];
         issue_cnt <= '0;
         recv_cnt <= '0;
      end else if (take) begin
         line[word_idx] <= mem_rdata;
         issue_cnt <= issue_cnt + 3'd1;
         recv_cnt <= recv_cnt + 4'd1;
      end
`ifdef ICACHE_CRIT_WORD_FIRST_EN
   always_ff @(posedge CLK)
      if (!RST_N) begin
         crit_valid <= 1'b0;
         crit_word <= '0;
      end else begin
         crit_valid <= take && recv_cnt == 4'd0;
         if (take && recv_cnt == 4'd0) crit_word <= mem_rdata;
      end
`else
   assign crit_valid = 1'b0;
   assign crit_word = '0;
`endif
   assign w0 = line[0];
   assign w1 = line[1];
   assign w2 = line[2];
   assign w3 = line[3];
   assign w4 = line[4];
   assign w5 = line[5];
   assign w6 = line[6];
   assign w7 = line[7];
endmodule
